// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares dataMemory between the MEM stage and a debug/loader port
//
// Purpose: the pipeline owns the single memory port transparently; the debug
// port takes idle slots, or after STARVE_LIMIT contended cycles takes a slot
// by force and stalls the pipeline for that one cycle. Addresses are checked
// against the implemented word map 0x0010..0x0018 (even addresses only).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   memRead4, memWrite4           pipeline load/store request (MEM stage)
//   aluResultOut, rdData2_3       pipeline address / store data
//   stall                         pipeline must hold MEM this cycle
//   pipeErr                       registered pulse: bad pipeline access
//   dbgReq, dbgWe, dbgAddr,
//   dbgWrData                     debug request, held until dbgAck
//   dbgAck, dbgRdData, dbgErr     debug completion pulse, read data, error
//   memReadOut, memWriteOut,
//   memAddr, memWrData            to dataMemory
//   memRdData                     from dataMemory (one cycle after read strobe)
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead4,
    input  logic        memWrite4,
    input  logic [15:0] aluResultOut,
    input  logic [15:0] rdData2_3,
    output logic        stall,
    output logic        pipeErr,
    input  logic        dbgReq,
    input  logic        dbgWe,
    input  logic [15:0] dbgAddr,
    input  logic [15:0] dbgWrData,
    output logic        dbgAck,
    output logic [15:0] dbgRdData,
    output logic        dbgErr,
    output logic        memReadOut,
    output logic        memWriteOut,
    output logic [15:0] memAddr,
    output logic [15:0] memWrData,
    input  logic [15:0] memRdData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRD  = 2'd1,
        DACK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    function automatic logic addr_mapped(input logic [15:0] a);
        return (a >= 16'h0010) && (a <= 16'h0018) && !a[0];
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [15:0]        dbg_rd_data_q, dbg_rd_data_d;
    logic               dbg_err_q, dbg_err_d;
    logic               pipe_err_q, pipe_err_d;
    logic               pipe_req;
    logic               dbg_grant;

    always_comb begin
        pipe_req  = memRead4 | memWrite4;
        // Grant is suppressed during reset so no strobe reaches the memory.
        dbg_grant = !rst && (state_q == IDLE) && dbgReq &&
                    (!pipe_req || (starve_cnt_q == LIMIT));
        stall     = dbg_grant && pipe_req;

        // Pipeline slot by default; a simultaneous read+write keeps only the write.
        memAddr     = aluResultOut;
        memWrData   = rdData2_3;
        memWriteOut = memWrite4 && !rst;
        memReadOut  = memRead4 && !memWrite4 && !rst;
        if (dbg_grant) begin
            memAddr     = dbgAddr;
            memWrData   = dbgWrData;
            memWriteOut = dbgWe;
            memReadOut  = !dbgWe;
        end

        // Only accesses actually forwarded to memory can be flagged.
        pipe_err_d = !dbg_grant &&
                     ((memRead4 && memWrite4) || (pipe_req && !addr_mapped(aluResultOut)));

        state_d       = state_q;
        dbg_rd_data_d = dbg_rd_data_q;
        dbg_err_d     = dbg_err_q;
        case (state_q)
            IDLE: if (dbg_grant) begin
                state_d   = dbgWe ? DACK : DRD;
                dbg_err_d = !addr_mapped(dbgAddr);
            end
            DRD: begin
                // memRdData here belongs to the debug read; a pipeline read
                // issued this cycle only lands on the following edge.
                dbg_rd_data_d = memRdData;
                state_d       = DACK;
            end
            DACK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        starve_cnt_d = starve_cnt_q;
        if (!dbgReq || dbg_grant) begin
            starve_cnt_d = '0;
        end else if ((state_q == IDLE) && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            dbg_rd_data_q <= 16'h0000;
            dbg_err_q     <= 1'b0;
            pipe_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_cnt_q  <= starve_cnt_d;
            dbg_rd_data_q <= dbg_rd_data_d;
            dbg_err_q     <= dbg_err_d;
            pipe_err_q    <= pipe_err_d;
        end
    end

    assign dbgAck    = (state_q == DACK);
    assign dbgErr    = dbgAck && dbg_err_q;
    assign dbgRdData = dbg_rd_data_q;
    assign pipeErr   = pipe_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        memRead4, memWrite4;
    logic [15:0] aluResultOut, rdData2_3;
    logic        stall, pipeErr;
    logic        dbgReq, dbgWe;
    logic [15:0] dbgAddr, dbgWrData;
    logic        dbgAck, dbgErr;
    logic [15:0] dbgRdData;
    logic        memReadOut, memWriteOut;
    logic [15:0] memAddr, memWrData;
    logic [15:0] memRdData = 16'h0000;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem [0:4];

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .memRead4(memRead4), .memWrite4(memWrite4),
        .aluResultOut(aluResultOut), .rdData2_3(rdData2_3),
        .stall(stall), .pipeErr(pipeErr),
        .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWrData(dbgWrData),
        .dbgAck(dbgAck), .dbgRdData(dbgRdData), .dbgErr(dbgErr),
        .memReadOut(memReadOut), .memWriteOut(memWriteOut),
        .memAddr(memAddr), .memWrData(memWrData), .memRdData(memRdData)
    );

    function automatic logic mapped(input logic [15:0] a);
        return (a >= 16'h0010) && (a <= 16'h0018) && !a[0];
    endfunction

    function automatic logic [2:0] widx(input logic [15:0] a);
        logic [15:0] off;
        off = a - 16'h0010;
        return off[3:1];
    endfunction

    // dataMemory model: write commits on negedge, read data registered on posedge.
    always @(negedge clk) if (memWriteOut && mapped(memAddr)) mem[widx(memAddr)] <= memWrData;
    always @(posedge clk) if (memReadOut && mapped(memAddr)) memRdData <= mem[widx(memAddr)];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_idle();
        memRead4 = 1'b0; memWrite4 = 1'b0; aluResultOut = 16'h0000; rdData2_3 = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 16'h0010; dbgWrData = 16'h1111;
        memRead4 = 1'b1; memWrite4 = 1'b1; aluResultOut = 16'h0044; rdData2_3 = 16'h9999;
        tick(); tick(); #1;
        vectors++; if (memReadOut !== 1'b0) begin miscompares++; $display("FAIL rst_memReadOut got %b want 0", memReadOut); end
        vectors++; if (memWriteOut !== 1'b0) begin miscompares++; $display("FAIL rst_memWriteOut got %b want 0", memWriteOut); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %b want 0", stall); end
        vectors++; if (memAddr !== 16'h0044) begin miscompares++; $display("FAIL rst_memAddr got %h want 0044", memAddr); end
        vectors++; if (memWrData !== 16'h9999) begin miscompares++; $display("FAIL rst_memWrData got %h want 9999", memWrData); end
        vectors++; if (dbgAck !== 1'b0 || dbgErr !== 1'b0 || pipeErr !== 1'b0) begin miscompares++; $display("FAIL rst_flags got ack=%b err=%b perr=%b want 000", dbgAck, dbgErr, pipeErr); end
        vectors++; if (dbgRdData !== 16'h0000) begin miscompares++; $display("FAIL rst_dbgRdData got %h want 0000", dbgRdData); end
        dbgReq = 1'b0; pipe_idle();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_idle_write_read();
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 16'h0014; dbgWrData = 16'hBEEF;
        #1;
        vectors++; if ({memWriteOut, memReadOut, stall} !== 3'b100) begin miscompares++; $display("FAIL wr_strobes got w/r/s=%b want 100", {memWriteOut, memReadOut, stall}); end
        vectors++; if (memAddr !== 16'h0014 || memWrData !== 16'hBEEF) begin miscompares++; $display("FAIL wr_bus got %h/%h want 0014/beef", memAddr, memWrData); end
        vectors++; if (dbgAck !== 1'b0) begin miscompares++; $display("FAIL wr_early_ack got %b want 0", dbgAck); end
        tick(); #1;
        vectors++; if (dbgAck !== 1'b1 || dbgErr !== 1'b0) begin miscompares++; $display("FAIL wr_ack got ack=%b err=%b want 1 0", dbgAck, dbgErr); end
        dbgReq = 1'b0;
        tick(); #1;
        vectors++; if (dbgAck !== 1'b0) begin miscompares++; $display("FAIL wr_ack_len got %b want 0", dbgAck); end
        vectors++; if (mem[2] !== 16'hBEEF) begin miscompares++; $display("FAIL wr_mem got %h want beef", mem[2]); end
        dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 16'h0014;
        #1;
        vectors++; if ({memReadOut, memWriteOut, stall} !== 3'b100) begin miscompares++; $display("FAIL rd_strobes got r/w/s=%b want 100", {memReadOut, memWriteOut, stall}); end
        tick(); #1;
        vectors++; if (dbgAck !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL rd_drd got ack=%b stall=%b want 0 0", dbgAck, stall); end
        tick(); #1;
        vectors++; if (dbgAck !== 1'b1 || dbgRdData !== 16'hBEEF || dbgErr !== 1'b0) begin miscompares++; $display("FAIL rd_ack got ack=%b data=%h err=%b want 1 beef 0", dbgAck, dbgRdData, dbgErr); end
        dbgReq = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        memRead4 = 1'b1; aluResultOut = 16'h0012;
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 16'h0010; dbgWrData = 16'h1234;
        for (int i = 0; i < 8; i++) begin
            #1;
            vectors++; if (stall !== 1'b0 || memReadOut !== 1'b1 || memAddr !== 16'h0012) begin miscompares++; $display("FAIL starve_c%0d got stall=%b rd=%b addr=%h want 0 1 0012", i, stall, memReadOut, memAddr); end
            tick();
        end
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL starve_stall got %b want 1", stall); end
        vectors++; if ({memWriteOut, memReadOut} !== 2'b10 || memAddr !== 16'h0010 || memWrData !== 16'h1234) begin miscompares++; $display("FAIL starve_bus got w/r=%b addr=%h data=%h want 10 0010 1234", {memWriteOut, memReadOut}, memAddr, memWrData); end
        vectors++; if (dut.starve_cnt_q !== 4'd8) begin miscompares++; $display("FAIL starve_cnt8 got %0d want 8", dut.starve_cnt_q); end
        tick(); #1;
        vectors++; if (dbgAck !== 1'b1 || stall !== 1'b0 || memReadOut !== 1'b1) begin miscompares++; $display("FAIL starve_ack got ack=%b stall=%b rd=%b want 1 0 1", dbgAck, stall, memReadOut); end
        vectors++; if (dut.starve_cnt_q !== 4'd0) begin miscompares++; $display("FAIL starve_cnt0 got %0d want 0", dut.starve_cnt_q); end
        vectors++; if (mem[0] !== 16'h1234) begin miscompares++; $display("FAIL starve_mem got %h want 1234", mem[0]); end
        dbgReq = 1'b0; pipe_idle();
        tick();
    endtask

    task automatic test_overlap();
        dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 16'h0016;
        #1;
        vectors++; if (memReadOut !== 1'b1 || memAddr !== 16'h0016) begin miscompares++; $display("FAIL ovl_issue got rd=%b addr=%h want 1 0016", memReadOut, memAddr); end
        tick();
        memRead4 = 1'b1; aluResultOut = 16'h0012;
        #1;
        vectors++; if (memReadOut !== 1'b1 || memAddr !== 16'h0012 || stall !== 1'b0) begin miscompares++; $display("FAIL ovl_pipe got rd=%b addr=%h stall=%b want 1 0012 0", memReadOut, memAddr, stall); end
        tick();
        pipe_idle();
        #1;
        vectors++; if (dbgAck !== 1'b1 || dbgRdData !== 16'h5555) begin miscompares++; $display("FAIL ovl_dbg got ack=%b data=%h want 1 5555", dbgAck, dbgRdData); end
        vectors++; if (memRdData !== 16'h00AA) begin miscompares++; $display("FAIL ovl_pipe_data got %h want 00aa", memRdData); end
        dbgReq = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 16'h0011; dbgWrData = 16'hDEAD;
        #1;
        vectors++; if (memWriteOut !== 1'b1) begin miscompares++; $display("FAIL err_strobe got %b want 1", memWriteOut); end
        tick(); #1;
        vectors++; if (dbgAck !== 1'b1 || dbgErr !== 1'b1) begin miscompares++; $display("FAIL err_dbg got ack=%b err=%b want 1 1", dbgAck, dbgErr); end
        dbgReq = 1'b0;
        tick(); #1;
        vectors++; if (mem[0] !== 16'h1234 || mem[1] !== 16'h00AA || mem[2] !== 16'hBEEF || mem[3] !== 16'h5555 || mem[4] !== 16'h0000) begin miscompares++; $display("FAIL err_mem got %h %h %h %h %h want 1234 00aa beef 5555 0000", mem[0], mem[1], mem[2], mem[3], mem[4]); end
        memRead4 = 1'b1; memWrite4 = 1'b1; aluResultOut = 16'h0018; rdData2_3 = 16'h7777;
        #1;
        vectors++; if ({memWriteOut, memReadOut} !== 2'b10 || pipeErr !== 1'b0) begin miscompares++; $display("FAIL err_rw_bus got w/r=%b perr=%b want 10 0", {memWriteOut, memReadOut}, pipeErr); end
        tick();
        pipe_idle();
        #1;
        vectors++; if (pipeErr !== 1'b1) begin miscompares++; $display("FAIL err_rw_perr got %b want 1", pipeErr); end
        vectors++; if (mem[4] !== 16'h7777) begin miscompares++; $display("FAIL err_rw_mem got %h want 7777", mem[4]); end
        memRead4 = 1'b1; aluResultOut = 16'h0020;
        tick();
        pipe_idle();
        #1;
        vectors++; if (pipeErr !== 1'b1) begin miscompares++; $display("FAIL err_unmapped_perr got %b want 1", pipeErr); end
        tick(); #1;
        vectors++; if (pipeErr !== 1'b0) begin miscompares++; $display("FAIL err_perr_pulse got %b want 0", pipeErr); end
    endtask

    task automatic test_reset_mid_read();
        dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 16'h0016;
        tick();
        rst = 1'b1;
        #1;
        vectors++; if (memReadOut !== 1'b0 || memWriteOut !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL rmid_strobes got r/w/s=%b want 000", {memReadOut, memWriteOut, stall}); end
        tick();
        rst = 1'b0; dbgReq = 1'b0;
        #1;
        vectors++; if (dbgAck !== 1'b0 || dbgRdData !== 16'h0000) begin miscompares++; $display("FAIL rmid_state got ack=%b data=%h want 0 0000", dbgAck, dbgRdData); end
        vectors++; if (dut.starve_cnt_q !== 4'd0) begin miscompares++; $display("FAIL rmid_cnt got %0d want 0", dut.starve_cnt_q); end
        tick(); #1;
        vectors++; if (dbgAck !== 1'b0) begin miscompares++; $display("FAIL rmid_late_ack got %b want 0", dbgAck); end
        dbgReq = 1'b1;
        #1;
        vectors++; if (memReadOut !== 1'b1 || memAddr !== 16'h0016) begin miscompares++; $display("FAIL rmid_reissue got rd=%b addr=%h want 1 0016", memReadOut, memAddr); end
        tick(); tick(); #1;
        vectors++; if (dbgAck !== 1'b1 || dbgRdData !== 16'h5555) begin miscompares++; $display("FAIL rmid_reread got ack=%b data=%h want 1 5555", dbgAck, dbgRdData); end
        dbgReq = 1'b0;
        tick();
    endtask

    initial begin
        mem[0] = 16'h0000; mem[1] = 16'h00AA; mem[2] = 16'h0000; mem[3] = 16'h5555; mem[4] = 16'h0000;
        pipe_idle();
        test_reset();
        test_idle_write_read();
        test_starvation();
        test_overlap();
        test_errors();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported `dataMemory` block between the pipeline MEM stage and a debug/loader port. The pipeline normally owns the memory transparently. The debug port takes idle slots, and after a bounded wait it takes a slot by force, stalling the pipeline for one cycle. The arbiter sits between the MEM-stage control signals (`memRead4`/`memWrite4`) and `dataMemory`, and also validates addresses against the implemented word map 0x0010–0x0018.

## Interface
- STARVE_LIMIT, 8: contended cycles a pending debug request waits before a forced grant (≥1).
- CNT_W, 4: starvation counter width; must hold STARVE_LIMIT.

- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- memRead4  in  1  pipeline load request (MEM stage).
- memWrite4  in  1  pipeline store request.
- aluResultOut  in  16  pipeline address.
- rdData2_3  in  16  pipeline store data.
- stall  out  1  pipeline must hold the MEM stage this cycle.
- pipeErr  out  1  registered pulse: pipeline access to an unmapped address, or read and write asserted together.
- dbgReq  in  1  debug request; held with its fields stable until `dbgAck`.
- dbgWe  in  1  1 = write, 0 = read.
- dbgAddr  in  16  debug address.
- dbgWrData  in  16  debug write data.
- dbgAck  out  1  one-cycle completion pulse.
- dbgRdData  out  16  read data, valid when `dbgAck` is high and `dbgWe` was 0.
- dbgErr  out  1  valid with `dbgAck`: address was unmapped.
- memReadOut  out  1  to `dataMemory` `memRead4`.
- memWriteOut  out  1  to `dataMemory` `memWrite4`.
- memAddr  out  16  to `dataMemory` `aluResultOut`.
- memWrData  out  16  to `dataMemory` `rdData2_3`.
- memRdData  in  16  from `dataMemory` `rdData3`.

## Operation
- **Mapped addresses:** 0x0010, 0x0012, 0x0014, 0x0016, 0x0018. Any other address is unmapped.
- **Unmapped accesses:** the arbiter still drives the strobe; the memory ignores it. The arbiter flags the error (`pipeErr` or `dbgErr`).
- **States:**
  - IDLE: debug port is free to issue.
  - DRD: debug read issued; waiting for data.
  - DACK: debug acknowledge cycle.
- **Slot owner each cycle (combinational):**
  - Debug owns the slot if the state is IDLE, `dbgReq`=1 and no pipeline request is present.
  - Debug also owns the slot if the state is IDLE, `dbgReq`=1 and `starveCnt` == STARVE_LIMIT.
  - Otherwise the pipeline owns the slot.
- **Forced grant with a pipeline request present:** `stall`=1, and the pipeline strobes are not forwarded. `stall`=0 in all other cases.
- **Memory mux:**
  - Pipeline slot: the pipeline signals pass through. If both `memRead4` and `memWrite4` are 1, the write wins, the read is dropped, and `pipeErr` is raised.
  - Debug slot: `memAddr`=`dbgAddr`, `memWrData`=`dbgWrData`, `memWriteOut`=`dbgWe`, `memReadOut`=!`dbgWe`.
- **`starveCnt`:**
  - Increments while the state is IDLE, `dbgReq`=1 and debug is not granted (saturates at STARVE_LIMIT).
  - Clears on any debug grant, and whenever `dbgReq`=0.
- **Debug write:** issue → DACK → IDLE.
- **Debug read:** issue → DRD → DACK → IDLE.
  - In DRD, `memRdData` is captured into `dbgRdData`.
  - The pipeline may use the memory during DRD and DACK. Its read updates `memRdData` only at the end of the DRD cycle, after the capture.
- **`dbgErr`:** registered at issue and presented with `dbgAck`.
- **Reset mid-transaction:** state returns to IDLE and no ack is produced. The debug master re-requests, and the memory contents are unaffected.

## Timing
- Reset values: state=IDLE, `starveCnt`=0, `dbgAck`=0, `dbgErr`=0, `dbgRdData`=0x0000, `pipeErr`=0.
  - While `rst`=1: `memReadOut`=0, `memWriteOut`=0 and `stall`=0. `memAddr` and `memWrData` follow the pipeline inputs.
- Pipeline accesses add zero latency. Read data appears on `memRdData` one cycle after the read strobe, matching the existing MEM→WB timing.
- Debug write issued in cycle N: `dbgAck` in N+1. The memory commits on the negedge within N.
- Debug read issued in cycle N: `dbgRdData` and `dbgAck` in N+2.
- `dbgAck` lasts exactly one cycle. The master may drop `dbgReq` in that cycle. A new request is considered from the cycle after `dbgAck`.
- Worst-case debug wait under continuous pipeline traffic: STARVE_LIMIT cycles, then 1 stall cycle.
- `pipeErr` is asserted in the cycle after the offending access.

## Test plan
- **Idle debug write/read:** with no pipeline traffic, debug writes 0xBEEF to 0x0014 at cycle N → `dbgAck`=1 at N+1, `dbgErr`=0. Then a debug read of 0x0014 → `dbgRdData`=0xBEEF with `dbgAck` two cycles after issue, and `stall` never asserted.
- **Starvation:** `memRead4`=1 every cycle while `dbgReq` (write 0x1234 → 0x0010) is held from cycle 0 → `stall`=1 exactly at cycle 8 (STARVE_LIMIT=8), memory write occurs in cycle 8, `dbgAck` at cycle 9, `starveCnt` back to 0.
- **Overlap:** pipeline reads 0x0012 (holding 0x00AA) in the DRD cycle of a debug read of 0x0016 (holding 0x5555) → `dbgRdData`=0x5555, pipeline `memRdData`=0x00AA the following cycle.
- **Errors:** debug write to 0x0011 → `dbgAck` with `dbgErr`=1, no mapped word changed. Pipeline with `memRead4`=`memWrite4`=1 at 0x0018 → write performed, `pipeErr` pulses one cycle later.
- **Reset mid-read:** assert `rst` in the DRD cycle → no `dbgAck`, state IDLE, `dbgRdData`=0x0000. Re-issuing the read returns the correct value.
